// File: rtl/pipeline_regs.sv
// IF/ID, ID/EX and EX/MEM pipeline registers sharing one clock and a synchronous reset.
// IF/ID can stall. When ID/EX is not enabled it loads a bubble that clears only the control fields.
module pipeline_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifid_en,
  input  logic [31:0] f_instr,
  input  logic [31:0] f_pc4,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc4,
  input  logic        idex_en,
  input  logic [31:0] id_pc4,
  input  logic [31:0] id_sext,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [5:0]  id_funct,
  input  logic [1:0]  id_aluop,
  input  logic        id_regwrite,
  input  logic        id_memtoreg,
  input  logic        id_branch,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_regdst,
  input  logic        id_alusrc,
  input  logic        id_zero,
  output logic [31:0] x_pc4,
  output logic [31:0] x_sext,
  output logic [31:0] x_rd1,
  output logic [31:0] x_rd2,
  output logic [4:0]  x_rs,
  output logic [4:0]  x_rt,
  output logic [4:0]  x_rd,
  output logic [5:0]  x_funct,
  output logic        x_zero,
  output logic [1:0]  x_wb,
  output logic [2:0]  x_m,
  output logic [3:0]  x_ex,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_write_data,
  input  logic [4:0]  ex_write_reg,
  input  logic [1:0]  ex_wb,
  input  logic [2:0]  ex_m,
  input  logic        ex_zero,
  output logic [31:0] m_alu_result,
  output logic [31:0] m_write_data,
  output logic [4:0]  m_write_reg,
  output logic [1:0]  m_wb,
  output logic [2:0]  m_m,
  output logic        m_zero
);

  // The declaration initialisers give the all-zero power-up state before the first reset.
  logic [31:0] ifid_instr_q = 32'd0, ifid_pc4_q = 32'd0;
  logic [31:0] ifid_instr_d, ifid_pc4_d;

  logic [31:0] idex_pc4_q = 32'd0, idex_sext_q = 32'd0, idex_rd1_q = 32'd0, idex_rd2_q = 32'd0;
  logic [4:0]  idex_rs_q = 5'd0, idex_rt_q = 5'd0, idex_rd_q = 5'd0;
  logic [5:0]  idex_funct_q = 6'd0;
  logic        idex_zero_q = 1'b0;
  logic [1:0]  idex_wb_q = 2'd0;
  logic [2:0]  idex_m_q = 3'd0;
  logic [3:0]  idex_ex_q = 4'd0;
  logic        idex_zero_d;
  logic [1:0]  idex_wb_d;
  logic [2:0]  idex_m_d;
  logic [3:0]  idex_ex_d;

  logic [31:0] exmem_alu_q = 32'd0, exmem_wdata_q = 32'd0;
  logic [4:0]  exmem_wreg_q = 5'd0;
  logic [1:0]  exmem_wb_q = 2'd0;
  logic [2:0]  exmem_m_q = 3'd0;
  logic        exmem_zero_q = 1'b0;

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    if (ifid_en) begin
      ifid_instr_d = f_instr;
      ifid_pc4_d   = f_pc4;
    end else begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
    end
  end

  // A bubble zeroes only the control fields. The data fields still pass through.
  always_comb begin
    idex_wb_d   = 2'd0;
    idex_m_d    = 3'd0;
    idex_ex_d   = 4'd0;
    idex_zero_d = 1'b0;
    if (idex_en) begin
      idex_wb_d   = {id_memtoreg, id_regwrite};
      idex_m_d    = {id_branch, id_memread, id_memwrite};
      idex_ex_d   = {id_regdst, id_aluop[1], id_aluop[0], id_alusrc};
      idex_zero_d = id_zero;
    end else begin
      idex_wb_d   = 2'd0;
      idex_m_d    = 3'd0;
      idex_ex_d   = 4'd0;
      idex_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr_q  <= 32'd0;
      ifid_pc4_q    <= 32'd0;
      idex_pc4_q    <= 32'd0;
      idex_sext_q   <= 32'd0;
      idex_rd1_q    <= 32'd0;
      idex_rd2_q    <= 32'd0;
      idex_rs_q     <= 5'd0;
      idex_rt_q     <= 5'd0;
      idex_rd_q     <= 5'd0;
      idex_funct_q  <= 6'd0;
      idex_zero_q   <= 1'b0;
      idex_wb_q     <= 2'd0;
      idex_m_q      <= 3'd0;
      idex_ex_q     <= 4'd0;
      exmem_alu_q   <= 32'd0;
      exmem_wdata_q <= 32'd0;
      exmem_wreg_q  <= 5'd0;
      exmem_wb_q    <= 2'd0;
      exmem_m_q     <= 3'd0;
      exmem_zero_q  <= 1'b0;
    end else begin
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc4_q    <= ifid_pc4_d;
      idex_pc4_q    <= id_pc4;
      idex_sext_q   <= id_sext;
      idex_rd1_q    <= id_rd1;
      idex_rd2_q    <= id_rd2;
      idex_rs_q     <= id_rs;
      idex_rt_q     <= id_rt;
      idex_rd_q     <= id_rd;
      idex_funct_q  <= id_funct;
      idex_zero_q   <= idex_zero_d;
      idex_wb_q     <= idex_wb_d;
      idex_m_q      <= idex_m_d;
      idex_ex_q     <= idex_ex_d;
      exmem_alu_q   <= ex_alu_result;
      exmem_wdata_q <= ex_write_data;
      exmem_wreg_q  <= ex_write_reg;
      exmem_wb_q    <= ex_wb;
      exmem_m_q     <= ex_m;
      exmem_zero_q  <= ex_zero;
    end
  end

  assign d_instr      = ifid_instr_q;
  assign d_pc4        = ifid_pc4_q;
  assign x_pc4        = idex_pc4_q;
  assign x_sext       = idex_sext_q;
  assign x_rd1        = idex_rd1_q;
  assign x_rd2        = idex_rd2_q;
  assign x_rs         = idex_rs_q;
  assign x_rt         = idex_rt_q;
  assign x_rd         = idex_rd_q;
  assign x_funct      = idex_funct_q;
  assign x_zero       = idex_zero_q;
  assign x_wb         = idex_wb_q;
  assign x_m          = idex_m_q;
  assign x_ex         = idex_ex_q;
  assign m_alu_result = exmem_alu_q;
  assign m_write_data = exmem_wdata_q;
  assign m_write_reg  = exmem_wreg_q;
  assign m_wb         = exmem_wb_q;
  assign m_m          = exmem_m_q;
  assign m_zero       = exmem_zero_q;

endmodule

// File: tb/tb_pipeline_regs.sv
// Directed self-checking bench for pipeline_regs. It covers reset, stall, bubble and the EX/MEM path.
module tb_pipeline_regs;

  logic        clk = 1'b0;
  logic        reset, ifid_en, idex_en;
  logic [31:0] f_instr, f_pc4, d_instr, d_pc4;
  logic [31:0] id_pc4, id_sext, id_rd1, id_rd2;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_aluop;
  logic        id_regwrite, id_memtoreg, id_branch, id_memread, id_memwrite, id_regdst, id_alusrc, id_zero;
  logic [31:0] x_pc4, x_sext, x_rd1, x_rd2;
  logic [4:0]  x_rs, x_rt, x_rd;
  logic [5:0]  x_funct;
  logic        x_zero;
  logic [1:0]  x_wb;
  logic [2:0]  x_m;
  logic [3:0]  x_ex;
  logic [31:0] ex_alu_result, ex_write_data, m_alu_result, m_write_data;
  logic [4:0]  ex_write_reg, m_write_reg;
  logic [1:0]  ex_wb, m_wb;
  logic [2:0]  ex_m, m_m;
  logic        ex_zero, m_zero;

  int checks = 0;
  int errors = 0;

  pipeline_regs dut (
    .clk(clk), .reset(reset), .ifid_en(ifid_en), .f_instr(f_instr), .f_pc4(f_pc4),
    .d_instr(d_instr), .d_pc4(d_pc4), .idex_en(idex_en),
    .id_pc4(id_pc4), .id_sext(id_sext), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_aluop(id_aluop),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_branch(id_branch),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_regdst(id_regdst),
    .id_alusrc(id_alusrc), .id_zero(id_zero),
    .x_pc4(x_pc4), .x_sext(x_sext), .x_rd1(x_rd1), .x_rd2(x_rd2),
    .x_rs(x_rs), .x_rt(x_rt), .x_rd(x_rd), .x_funct(x_funct), .x_zero(x_zero),
    .x_wb(x_wb), .x_m(x_m), .x_ex(x_ex),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg),
    .ex_wb(ex_wb), .ex_m(ex_m), .ex_zero(ex_zero),
    .m_alu_result(m_alu_result), .m_write_data(m_write_data), .m_write_reg(m_write_reg),
    .m_wb(m_wb), .m_m(m_m), .m_zero(m_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " d_instr"}, d_instr, 32'd0);
    check({tag, " d_pc4"}, d_pc4, 32'd0);
    check({tag, " x_data"}, x_pc4 | x_sext | x_rd1 | x_rd2, 32'd0);
    check({tag, " x_regs"}, {11'd0, x_rs, x_rt, x_rd, x_funct}, 32'd0);
    check({tag, " x_ctrl"}, {22'd0, x_zero, x_wb, x_m, x_ex}, 32'd0);
    check({tag, " m_data"}, m_alu_result | m_write_data, 32'd0);
    check({tag, " m_ctrl"}, {21'd0, m_write_reg, m_wb, m_m, m_zero}, 32'd0);
  endtask

  task automatic set_all_ones();
    ifid_en = 1'b1; idex_en = 1'b1;
    f_instr = 32'hFFFF_FFFF; f_pc4 = 32'hFFFF_FFFF;
    id_pc4 = 32'hFFFF_FFFF; id_sext = 32'hFFFF_FFFF; id_rd1 = 32'hFFFF_FFFF; id_rd2 = 32'hFFFF_FFFF;
    id_rs = 5'h1F; id_rt = 5'h1F; id_rd = 5'h1F; id_funct = 6'h3F; id_aluop = 2'b11;
    {id_regwrite, id_memtoreg, id_branch, id_memread, id_memwrite, id_regdst, id_alusrc, id_zero} = 8'hFF;
    ex_alu_result = 32'hFFFF_FFFF; ex_write_data = 32'hFFFF_FFFF; ex_write_reg = 5'h1F;
    ex_wb = 2'b11; ex_m = 3'b111; ex_zero = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_all_ones();
    #1;
    check_all_zero("powerup");

    // Reset with every input and enable active.
    reset = 1'b1;
    step();
    check_all_zero("reset1");
    ifid_en = 1'b0; idex_en = 1'b0;
    step();
    check_all_zero("reset2");
    ifid_en = 1'b1; idex_en = 1'b1;
    step();
    check_all_zero("reset3");

    // Normal load on all three stages.
    reset = 1'b0;
    f_instr = 32'h8C22_0004; f_pc4 = 32'h0000_0008;
    id_pc4 = 32'h0000_0004; id_sext = 32'hFFFF_FFFC; id_rd1 = 32'h1111_2222; id_rd2 = 32'h8000_0001;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_funct = 6'h20; id_aluop = 2'b10;
    id_regdst = 1'b1; id_alusrc = 1'b0; id_regwrite = 1'b1; id_memtoreg = 1'b0;
    id_branch = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0; id_zero = 1'b1;
    ex_alu_result = 32'h0000_0010; ex_write_data = 32'hDEAD_BEEF; ex_write_reg = 5'd9;
    ex_wb = 2'b11; ex_m = 3'b010; ex_zero = 1'b0;
    step();
    check("load d_instr", d_instr, 32'h8C22_0004);
    check("load d_pc4", d_pc4, 32'h0000_0008);
    check("load x_ex", x_ex, 4'b1100);
    check("load x_wb", x_wb, 2'b01);
    check("load x_m", x_m, 3'b000);
    check("load x_rd", x_rd, 5'd3);
    check("load x_rs", x_rs, 5'd1);
    check("load x_rt", x_rt, 5'd2);
    check("load x_funct", x_funct, 6'h20);
    check("load x_zero", x_zero, 1'b1);
    check("load x_pc4", x_pc4, 32'h0000_0004);
    check("load x_sext", x_sext, 32'hFFFF_FFFC);
    check("load x_rd1", x_rd1, 32'h1111_2222);
    check("load x_rd2", x_rd2, 32'h8000_0001);
    check("load m_alu", m_alu_result, 32'h0000_0010);
    check("load m_wdata", m_write_data, 32'hDEAD_BEEF);
    check("load m_wreg", m_write_reg, 5'd9);
    check("load m_wb", m_wb, 2'b11);
    check("load m_m", m_m, 3'b010);
    check("load m_zero", m_zero, 1'b0);

    // Stall IF/ID and bubble ID/EX together. EX/MEM keeps loading.
    ifid_en = 1'b0; f_instr = 32'h0000_0000; f_pc4 = 32'h0000_0000;
    idex_en = 1'b0; id_memread = 1'b1; id_regwrite = 1'b1; id_memtoreg = 1'b1;
    id_rt = 5'd7; id_pc4 = 32'h0000_0100; id_zero = 1'b1;
    ex_alu_result = 32'h0000_0020; ex_write_data = 32'h0BAD_F00D; ex_write_reg = 5'd17;
    ex_wb = 2'b10; ex_m = 3'b101; ex_zero = 1'b1;
    step();
    check("stall d_instr", d_instr, 32'h8C22_0004);
    check("stall d_pc4", d_pc4, 32'h0000_0008);
    check("bubble x_wb", x_wb, 2'b00);
    check("bubble x_m", x_m, 3'b000);
    check("bubble x_ex", x_ex, 4'b0000);
    check("bubble x_zero", x_zero, 1'b0);
    check("bubble x_rt", x_rt, 5'd7);
    check("bubble x_pc4", x_pc4, 32'h0000_0100);
    check("bubble m_alu", m_alu_result, 32'h0000_0020);
    check("bubble m_wdata", m_write_data, 32'h0BAD_F00D);
    check("bubble m_wreg", m_write_reg, 5'd17);
    check("bubble m_ctrl", {m_wb, m_m, m_zero}, 6'b10_101_1);

    // Reset arrives during the stall and the bubble, with the EX/MEM inputs live.
    ex_alu_result = 32'h0000_0010; ex_write_data = 32'hDEAD_BEEF; ex_write_reg = 5'd9;
    ex_wb = 2'b11; ex_m = 3'b010;
    reset = 1'b1;
    step();
    check_all_zero("midstall_reset");

    // First edge after reset is released loads normally, with new control packing.
    reset = 1'b0;
    ifid_en = 1'b1; f_instr = 32'h1234_5678; f_pc4 = 32'h0000_00A0;
    idex_en = 1'b1; id_regdst = 1'b0; id_aluop = 2'b01; id_alusrc = 1'b1;
    id_branch = 1'b1; id_memread = 1'b0; id_memwrite = 1'b1; id_regwrite = 1'b0; id_memtoreg = 1'b1;
    step();
    check("post d_instr", d_instr, 32'h1234_5678);
    check("post d_pc4", d_pc4, 32'h0000_00A0);
    check("post x_ex", x_ex, 4'b0011);
    check("post x_m", x_m, 3'b101);
    check("post x_wb", x_wb, 2'b10);
    check("post m_alu", m_alu_result, 32'h0000_0010);

    // IF/ID loads while ID/EX inserts a bubble.
    f_instr = 32'hCAFE_0001; idex_en = 1'b0; id_rd = 5'd31;
    step();
    check("indep d_instr", d_instr, 32'hCAFE_0001);
    check("indep x_ctrl", {x_wb, x_m, x_ex}, 9'd0);
    check("indep x_rd", x_rd, 5'd31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
